// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential single-multiplier FIR multiply-accumulate stage
module fir_mac_seq #(
    parameter int N         = 8,
    parameter int SIZE      = 8,
    parameter int COEF_SIZE = 8,
    parameter int ACC_SIZE  = 19
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [N*SIZE-1:0]          taps,
    input  logic [N*COEF_SIZE-1:0]     coeffs,
    output logic                       busy,
    output logic signed [ACC_SIZE-1:0] y,
    output logic                       y_valid
);

    localparam int IDX_W  = $clog2(N);
    localparam int PROD_W = SIZE + COEF_SIZE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_SIZE-1:0] acc_q, acc_d;
    logic signed [ACC_SIZE-1:0] y_q, y_d;
    logic                       y_valid_q, y_valid_d;
    logic                       snap_load;

    logic signed [SIZE-1:0]      snap_tap_q  [N];
    logic signed [COEF_SIZE-1:0] snap_coef_q [N];

    logic signed [SIZE-1:0]      cur_tap;
    logic signed [COEF_SIZE-1:0] cur_coef;
    logic signed [PROD_W-1:0]    prod;

    assign cur_tap  = snap_tap_q[idx_q];
    assign cur_coef = snap_coef_q[idx_q];
    assign prod     = cur_tap * cur_coef;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        snap_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_load = 1'b1;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // product is sign-extended; wraps modulo 2^ACC_SIZE if the width rule is broken
                acc_d = acc_q + ACC_SIZE'(prod);
                if (idx_q == IDX_W'(N - 1)) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                y_d       = acc_q;
                y_valid_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    // Snapshot decouples the result from tap-line shifts after the request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                snap_tap_q[i]  <= '0;
                snap_coef_q[i] <= '0;
            end
        end else if (snap_load) begin
            for (int i = 0; i < N; i++) begin
                snap_tap_q[i]  <= taps[i*SIZE +: SIZE];
                snap_coef_q[i] <= coeffs[i*COEF_SIZE +: COEF_SIZE];
            end
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - randomized scoreboard bench for fir_mac_seq
module tb_fir_mac_seq;

    localparam int N         = 8;
    localparam int SIZE      = 8;
    localparam int COEF_SIZE = 8;
    localparam int ACC_SIZE  = 19;

    logic                       clk;
    logic                       rst_n;
    logic                       start;
    logic [N*SIZE-1:0]          taps_v;
    logic [N*COEF_SIZE-1:0]     coeffs_v;
    logic                       busy;
    logic signed [ACC_SIZE-1:0] y;
    logic                       y_valid;

    fir_mac_seq #(
        .N(N), .SIZE(SIZE), .COEF_SIZE(COEF_SIZE), .ACC_SIZE(ACC_SIZE)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .taps(taps_v), .coeffs(coeffs_v),
        .busy(busy), .y(y), .y_valid(y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                         due;
        logic signed [ACC_SIZE-1:0] val;
    } exp_t;

    exp_t                       exp_q[$];
    int                         tests = 0;
    int                         fails = 0;
    int                         edge_cnt = 0;
    int                         model_wait = 0;
    logic signed [ACC_SIZE-1:0] model_y = '0;

    // Reference: plain dot product of the sample and coefficient vectors
    function automatic logic signed [ACC_SIZE-1:0] ref_sum();
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'($signed(taps_v[i*SIZE +: SIZE])) * longint'($signed(coeffs_v[i*COEF_SIZE +: COEF_SIZE]));
        return ACC_SIZE'(s);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // One clock: drive start, apply the model at the edge, then check steady outputs
    task automatic step(input bit st);
        exp_t e;
        @(negedge clk);
        start = st;
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) begin
            exp_q.delete();
            model_wait = 0;
            model_y    = '0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) model_y = exp_q[0].val;
            if (model_wait == 0 && st) begin
                e.due = edge_cnt + N + 1;
                e.val = ref_sum();
                exp_q.push_back(e);
                model_wait = N + 1;
            end else if (model_wait > 0) begin
                model_wait--;
            end
        end
        #1;
        check("busy", longint'(busy), longint'(model_wait > 0));
        check("y_hold", longint'(y), longint'(model_y));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (y_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_y_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y_value", longint'(y), longint'(e.val));
                    check("y_valid_edge", longint'(edge_cnt), longint'(e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
                e = exp_q.pop_front();
                check("missing_y_valid", longint'(edge_cnt), longint'(e.due));
            end
        end
    end

    task automatic set_ramp_ones();
        for (int i = 0; i < N; i++) begin
            taps_v[i*SIZE +: SIZE]            = SIZE'(i + 1);
            coeffs_v[i*COEF_SIZE +: COEF_SIZE] = COEF_SIZE'(1);
        end
    endtask

    task automatic set_fill(input logic [SIZE-1:0] t, input logic [COEF_SIZE-1:0] c);
        for (int i = 0; i < N; i++) begin
            taps_v[i*SIZE +: SIZE]            = t;
            coeffs_v[i*COEF_SIZE +: COEF_SIZE] = c;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        taps_v   = '0;
        coeffs_v = '0;
        idle(3);
        rst_n = 1'b1;

        // idle after reset
        idle(20);

        // basic ramp, expect 36
        set_ramp_ones();
        check("ref_basic", longint'(ref_sum()), 36);
        step(1'b1);
        idle(12);

        // signed extremes
        set_fill(8'h80, 8'h80);
        check("ref_neg_neg", longint'(ref_sum()), 131072);
        step(1'b1);
        idle(12);
        set_fill(8'h80, 8'h7F);
        check("ref_neg_pos", longint'(ref_sum()), -130048);
        step(1'b1);
        idle(12);

        // snapshot: taps change and start held during RUN
        set_ramp_ones();
        step(1'b1);
        set_fill(8'h7F, 8'h01);
        for (int i = 0; i < 12; i++) step(1'b1);
        idle(14);

        // back-to-back: second start on the y_valid cycle
        set_ramp_ones();
        step(1'b1);
        idle(N + 1);
        set_fill(8'h00, 8'h00);
        taps_v[SIZE-1:0]       = 8'd5;
        coeffs_v[COEF_SIZE-1:0] = 8'd2;
        step(1'b1);
        idle(14);

        // asynchronous reset at idx=4
        set_ramp_ones();
        coeffs_v[COEF_SIZE-1:0] = 8'd3;
        step(1'b1);
        idle(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_y_valid", longint'(y_valid), 0);
        check("rst_y", longint'(y), 0);
        exp_q.delete();
        model_wait = 0;
        model_y    = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        step(1'b1);
        idle(12);

        // randomized traffic with a moving tap line
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                taps_v[k*SIZE +: SIZE]            = SIZE'($urandom);
                coeffs_v[k*COEF_SIZE +: COEF_SIZE] = COEF_SIZE'($urandom);
            end
            step($urandom_range(0, 99) < 40);
        end
        idle(N + 6);
        check("scoreboard_drained", longint'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Time-multiplexed multiply-accumulate stage directly downstream of the FIR tap delay line. It consumes the N-tap parallel sample vector and an N-coefficient vector and produces one filtered output per start request, using one signed multiplier reused over N cycles. Control is a start/busy/valid handshake. The handshake is driven by the FIR top level one cycle after the delay line shifts.

Parameters:
N, 8, number of taps; must be ≥2
SIZE, 8, sample width in bits, signed two's complement
COEF_SIZE, 8, coefficient width in bits, signed two's complement
ACC_SIZE, 19, accumulator/output width; must be ≥ SIZE+COEF_SIZE+ceil(log2(N))

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request one output computation; sampled only in IDLE
taps  input  N*SIZE  tap i = taps[i*SIZE +: SIZE]; tap 0 = newest sample (LSBs)
coeffs  input  N*COEF_SIZE  coef i = coeffs[i*COEF_SIZE +: COEF_SIZE]; multiplies tap i
busy  output  1  high in RUN and DONE
y  output  ACC_SIZE  signed filter result; held until the next result
y_valid  output  1  single-cycle pulse marking a new y

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, idx=0, acc=0, y=0, y_valid=0, busy=0, snapshot registers=0. Outputs stay at these values while reset is low.
- States: IDLE, RUN, DONE.
- IDLE: when start=1 at edge E0:
  - snapshot taps and coeffs into internal registers
  - acc<=0, idx<=0, state<=RUN
  - start=0 leaves the block in IDLE.
- RUN, edges E1..EN:
  - acc <= acc + sext(snap_tap[idx]) * sext(snap_coef[idx]), full signed product sign-extended to ACC_SIZE
  - idx<=idx+1
  - at the edge that accumulates idx=N-1: idx<=0, state<=DONE.
- DONE, edge EN+1: y<=acc, y_valid<=1, state<=IDLE.
- y_valid is deasserted at every other edge, so it is high for exactly one cycle.
- Latency: y_valid is high in the cycle after edge E(N+1), i.e. N+1 edges after start is sampled. Throughput: one result per N+2 cycles maximum.
- start while busy=1 is ignored. It is not queued and does not affect the computation in progress.
- start in the cycle where y_valid=1 (state IDLE) is accepted. This gives the back-to-back rate above.
- Changes on taps/coeffs after E0 have no effect on the current result; only the snapshot is used.
- Overflow: not possible within the ACC_SIZE rule; no saturation logic. Wrap modulo 2^ACC_SIZE if the parameter rule is violated.
- Reset mid-operation (RUN or DONE): abort immediately, return to the reset values above, and emit no y_valid for the aborted request.
- y holds its last value while IDLE, RUN and DONE until overwritten at the next DONE edge.

Test Plan:
- Reset then idle: no start for 20 cycles -> y=0, y_valid=0, busy=0 throughout.
- Basic: N=8, coeffs all +1, taps i=i+1 (1..8), pulse start -> busy high 9 cycles, y_valid one cycle N+1 edges after start, y=36.
- Signed extremes: all taps=-128, all coeffs=-128 -> y=131072; then taps all -128, coeffs all +127 -> y=-130048 (0x60400 in 19 bits).
- Snapshot/ignore: start with taps=1..8 and coeffs=+1, change taps to all 0x7F and hold start high during RUN -> y=36, exactly one y_valid, next computation starts only on the y_valid cycle if start is still high.
- Back-to-back: start asserted on the y_valid cycle with coeff 0 set to +2 and the others 0, tap0=5 -> second y_valid 10 cycles after the first, y=10.
- Reset mid-RUN: assert reset=0 asynchronously at idx=4 -> busy=0, y_valid=0, y=0 immediately with no clock edge needed; a following start gives the correct fresh result.
